// File: rtl/bp_pkg.sv
// Shared helpers for the branch target predictor: width derivation and
// saturating direction-counter arithmetic (counters are at most 3 bits wide).
package bp_pkg;

    localparam int unsigned CTR_W_MAX = 3;

    function automatic int unsigned idx_width(input int unsigned entries);
        return $clog2(entries);
    endfunction

    function automatic int unsigned tag_width(input int unsigned pc_w, input int unsigned align,
                                              input int unsigned entries);
        return pc_w - align - $clog2(entries);
    endfunction

    // Weakly-not-taken: just below the taken threshold
    function automatic logic [CTR_W_MAX-1:0] ctr_weak_nt(input int unsigned ctr_w);
        return CTR_W_MAX'((1 << (ctr_w - 1)) - 1);
    endfunction

    // Weakly-taken: lowest value with the MSB set
    function automatic logic [CTR_W_MAX-1:0] ctr_weak_t(input int unsigned ctr_w);
        return CTR_W_MAX'(1 << (ctr_w - 1));
    endfunction

    function automatic logic [CTR_W_MAX-1:0] ctr_max(input int unsigned ctr_w);
        return CTR_W_MAX'((1 << ctr_w) - 1);
    endfunction

    // Saturating increment (inc=1) or decrement (inc=0) bounded by [0, max]
    function automatic logic [CTR_W_MAX-1:0] ctr_next(input logic [CTR_W_MAX-1:0] ctr,
                                                      input logic inc,
                                                      input logic [CTR_W_MAX-1:0] max);
        if (inc) begin
            return (ctr >= max) ? max : ctr + 1'b1;
        end
        return (ctr == '0) ? '0 : ctr - 1'b1;
    endfunction

endpackage

// File: rtl/bp_perf_counter.sv
// Saturating event counter: increments on en, sticks at all-ones.
module bp_perf_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    // Count enabled cycles until the counter is full
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (en && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters. Lookup is combinational off registered state; training from the
// ID-stage resolver lands on the next clock edge with no bypass.
module branch_target_predictor
    import bp_pkg::*;
#(
    parameter int unsigned PC_W    = 16,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned ALIGN   = 1,
    parameter int unsigned CTR_W   = 2,
    parameter int unsigned PERF_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lookup_en,
    input  logic [PC_W-1:0]   lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [PC_W-1:0]   pred_next_pc,
    input  logic              upd_valid,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic              upd_taken,
    input  logic              upd_is_jump,
    input  logic [PC_W-1:0]   upd_target,
    input  logic              upd_mispredict,
    input  logic              flush_all,
    output logic [PERF_W-1:0] stat_lookups,
    output logic [PERF_W-1:0] stat_hits,
    output logic [PERF_W-1:0] stat_mispredicts
);

    localparam int unsigned IDX_W = idx_width(ENTRIES);
    localparam int unsigned TAG_W = tag_width(PC_W, ALIGN, ENTRIES);

    localparam logic [CTR_W-1:0] WEAK_NT = CTR_W'(ctr_weak_nt(CTR_W));
    localparam logic [CTR_W-1:0] WEAK_T  = CTR_W'(ctr_weak_t(CTR_W));
    localparam logic [CTR_W-1:0] CTR_MAX = CTR_W'(ctr_max(CTR_W));
    localparam logic [PC_W-1:0]  STEP    = PC_W'(1) << ALIGN;

    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [PC_W-1:0]  r_target [ENTRIES];
    logic [CTR_W-1:0] r_ctr    [ENTRIES];

    // ---------------- Lookup ----------------
    logic [IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic             w_lk_match;

    assign w_lk_idx   = lookup_pc[ALIGN +: IDX_W];
    assign w_lk_tag   = lookup_pc[PC_W-1 -: TAG_W];
    assign w_lk_match = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);

    assign pred_hit     = lookup_en && w_lk_match;
    assign pred_taken   = pred_hit && r_ctr[w_lk_idx][CTR_W-1];
    assign pred_next_pc = pred_taken ? r_target[w_lk_idx] : lookup_pc + STEP;

    // ---------------- Update ----------------
    logic [IDX_W-1:0] w_up_idx;
    logic [TAG_W-1:0] w_up_tag;
    logic             w_up_fire;
    logic             w_up_hit;
    logic             w_up_taken;
    logic             w_up_write;
    logic [CTR_W-1:0] w_ctr_new;

    assign w_up_idx   = upd_pc[ALIGN +: IDX_W];
    assign w_up_tag   = upd_pc[PC_W-1 -: TAG_W];
    // A same-cycle flush cancels the update entirely
    assign w_up_fire  = upd_valid && !flush_all;
    assign w_up_hit   = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    assign w_up_taken = upd_taken || upd_is_jump;
    // Hits always train; misses only allocate when taken
    assign w_up_write = w_up_fire && (w_up_hit || w_up_taken);

    // Next counter value for the entry being trained or allocated
    always_comb begin
        w_ctr_new = WEAK_T;
        if (upd_is_jump) begin
            w_ctr_new = CTR_MAX;
        end else if (w_up_hit) begin
            w_ctr_new = CTR_W'(ctr_next(CTR_W_MAX'(r_ctr[w_up_idx]), w_up_taken,
                                        CTR_W_MAX'(CTR_MAX)));
        end
    end

    // Valid bits: async clear, flush has priority over allocation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) r_valid[i] <= 1'b0;
        end else if (flush_all) begin
            for (int i = 0; i < ENTRIES; i++) r_valid[i] <= 1'b0;
        end else if (w_up_fire && w_up_taken) begin
            r_valid[w_up_idx] <= 1'b1;
        end
    end

    // Direction counters: async reset to weakly-not-taken, survive flushes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= WEAK_NT;
        end else if (w_up_write) begin
            r_ctr[w_up_idx] <= w_ctr_new;
        end
    end

    // Tag and target are only meaningful under valid, so they carry no reset
    always_ff @(posedge clk) begin
        if (w_up_fire && w_up_taken) begin
            r_tag[w_up_idx]    <= w_up_tag;
            r_target[w_up_idx] <= upd_target;
        end
    end

    generate
        if (ALIGN > 0) begin : g_unused_lsb
            logic w_unused_upd_lsb;
            assign w_unused_upd_lsb = ^upd_pc[ALIGN-1:0];
        end
    endgenerate

    // ---------------- Statistics ----------------
    bp_perf_counter #(.W(PERF_W)) u_stat_lookups (
        .clk   (clk),
        .rst   (rst),
        .en    (lookup_en),
        .count (stat_lookups)
    );

    bp_perf_counter #(.W(PERF_W)) u_stat_hits (
        .clk   (clk),
        .rst   (rst),
        .en    (pred_hit),
        .count (stat_hits)
    );

    bp_perf_counter #(.W(PERF_W)) u_stat_mispredicts (
        .clk   (clk),
        .rst   (rst),
        .en    (upd_valid && upd_mispredict),
        .count (stat_mispredicts)
    );

endmodule

// File: tb/tb_branch_target_predictor.sv
// Scoreboard bench for branch_target_predictor: the driver queues expected
// lookup results and raises drv_chk; the monitor pops and compares on the
// falling edge.
module tb_branch_target_predictor;

    localparam int unsigned PC_W   = 16;
    localparam int unsigned PERF_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              lookup_en = 1'b0;
    logic [PC_W-1:0]   lookup_pc = '0;
    logic              pred_hit;
    logic              pred_taken;
    logic [PC_W-1:0]   pred_next_pc;
    logic              upd_valid = 1'b0;
    logic [PC_W-1:0]   upd_pc = '0;
    logic              upd_taken = 1'b0;
    logic              upd_is_jump = 1'b0;
    logic [PC_W-1:0]   upd_target = '0;
    logic              upd_mispredict = 1'b0;
    logic              flush_all = 1'b0;
    logic [PERF_W-1:0] stat_lookups;
    logic [PERF_W-1:0] stat_hits;
    logic [PERF_W-1:0] stat_mispredicts;

    branch_target_predictor #(
        .PC_W    (PC_W),
        .ENTRIES (16),
        .ALIGN   (1),
        .CTR_W   (2),
        .PERF_W  (PERF_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .lookup_en        (lookup_en),
        .lookup_pc        (lookup_pc),
        .pred_hit         (pred_hit),
        .pred_taken       (pred_taken),
        .pred_next_pc     (pred_next_pc),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_is_jump      (upd_is_jump),
        .upd_target       (upd_target),
        .upd_mispredict   (upd_mispredict),
        .flush_all        (flush_all),
        .stat_lookups     (stat_lookups),
        .stat_hits        (stat_hits),
        .stat_mispredicts (stat_mispredicts)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        hit;
        logic        taken;
        logic [15:0] npc;
        bit          chk_st;
        logic [3:0]  lk;
        logic [3:0]  ht;
        logic [3:0]  mp;
    } exp_t;

    exp_t exp_q[$];
    bit   drv_chk = 1'b0;
    int   checks = 0;
    int   failures = 0;

    task automatic cmp(input string nm, input string field, input logic [15:0] act,
                       input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s.%s: got %h, expected %h", nm, field, act, req);
        end
    endtask

    // Monitor: compare whenever the driver presents a checked cycle
    always @(negedge clk) begin
        if (drv_chk) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_underflow: got empty queue, expected an entry");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                cmp(e.name, "hit",     {15'd0, pred_hit},   {15'd0, e.hit});
                cmp(e.name, "taken",   {15'd0, pred_taken}, {15'd0, e.taken});
                cmp(e.name, "next_pc", pred_next_pc,        e.npc);
                if (e.chk_st) begin
                    cmp(e.name, "lookups",     {12'd0, stat_lookups},     {12'd0, e.lk});
                    cmp(e.name, "hits",        {12'd0, stat_hits},        {12'd0, e.ht});
                    cmp(e.name, "mispredicts", {12'd0, stat_mispredicts}, {12'd0, e.mp});
                end
            end
        end
    end

    task automatic drive(input logic le, input logic [15:0] pc, input logic uv,
                         input logic [15:0] upc, input logic ut, input logic uj,
                         input logic [15:0] utg, input logic um, input logic fl);
        @(posedge clk);
        #1;
        lookup_en      = le;
        lookup_pc      = pc;
        upd_valid      = uv;
        upd_pc         = upc;
        upd_taken      = ut;
        upd_is_jump    = uj;
        upd_target     = utg;
        upd_mispredict = um;
        flush_all      = fl;
        drv_chk        = 1'b0;
    endtask

    task automatic look(input logic le, input logic [15:0] pc);
        drive(le, pc, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic upd(input logic [15:0] upc, input logic ut, input logic uj,
                       input logic [15:0] utg, input logic um);
        drive(1'b0, 16'h0, 1'b1, upc, ut, uj, utg, um, 1'b0);
    endtask

    task automatic expect_lk(input string nm, input logic h, input logic t,
                             input logic [15:0] npc);
        exp_t e;
        e = '{name: nm, hit: h, taken: t, npc: npc, chk_st: 1'b0, lk: 4'h0, ht: 4'h0, mp: 4'h0};
        exp_q.push_back(e);
        drv_chk = 1'b1;
    endtask

    task automatic expect_all(input string nm, input logic h, input logic t,
                              input logic [15:0] npc, input logic [3:0] lk,
                              input logic [3:0] ht, input logic [3:0] mp);
        exp_t e;
        e = '{name: nm, hit: h, taken: t, npc: npc, chk_st: 1'b1, lk: lk, ht: ht, mp: mp};
        exp_q.push_back(e);
        drv_chk = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held from time zero
        look(1'b1, 16'h0040);
        expect_all("reset", 1'b0, 1'b0, 16'h0042, 4'd0, 4'd0, 4'd0);
        upd(16'h0010, 1'b1, 1'b0, 16'h0100, 1'b1);
        rst = 1'b1;

        look(1'b1, 16'h0010);
        expect_all("alloc", 1'b1, 1'b1, 16'h0100, 4'd0, 4'd0, 4'd1);
        upd(16'h0010, 1'b0, 1'b0, 16'h0000, 1'b0);
        upd(16'h0010, 1'b0, 1'b0, 16'h0000, 1'b0);
        look(1'b1, 16'h0010);
        expect_all("train_nt", 1'b1, 1'b0, 16'h0012, 4'd1, 4'd1, 4'd1);

        // Lookup alongside an update to the same entry sees the old contents
        drive(1'b1, 16'h0010, 1'b1, 16'h0010, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
        expect_lk("same_cycle", 1'b1, 1'b0, 16'h0012);
        drive(1'b1, 16'h0010, 1'b1, 16'h0010, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
        expect_lk("train_t1", 1'b1, 1'b0, 16'h0012);
        drive(1'b1, 16'h0010, 1'b1, 16'h0010, 1'b1, 1'b0, 16'h0200, 1'b0, 1'b0);
        expect_lk("train_t2", 1'b1, 1'b1, 16'h0100);
        drive(1'b1, 16'h0010, 1'b1, 16'h0010, 1'b1, 1'b0, 16'h0200, 1'b0, 1'b0);
        expect_all("train_t3", 1'b1, 1'b1, 16'h0200, 4'd5, 4'd5, 4'd1);
        // Counter held at 3, so one not-taken leaves it taken
        upd(16'h0010, 1'b0, 1'b0, 16'h0000, 1'b0);
        look(1'b1, 16'h0010);
        expect_all("ctr_sat", 1'b1, 1'b1, 16'h0200, 4'd6, 4'd6, 4'd1);

        // Alias: same index, different tag replaces the entry
        upd(16'h0030, 1'b1, 1'b0, 16'h0300, 1'b1);
        look(1'b1, 16'h0010);
        expect_all("alias_old", 1'b0, 1'b0, 16'h0012, 4'd7, 4'd7, 4'd2);
        look(1'b1, 16'h0030);
        expect_all("alias_new", 1'b1, 1'b1, 16'h0300, 4'd8, 4'd7, 4'd2);
        upd(16'h0050, 1'b0, 1'b0, 16'h0000, 1'b0);
        look(1'b1, 16'h0030);
        expect_all("miss_nt", 1'b1, 1'b1, 16'h0300, 4'd9, 4'd8, 4'd2);

        // Jump with taken=0 allocates at max; one not-taken still predicts taken
        upd(16'h0070, 1'b0, 1'b1, 16'h0500, 1'b0);
        upd(16'h0070, 1'b0, 1'b0, 16'h0000, 1'b0);
        look(1'b1, 16'h0070);
        expect_all("jump_max", 1'b1, 1'b1, 16'h0500, 4'd10, 4'd9, 4'd2);

        // Flush beats a same-cycle update
        drive(1'b1, 16'h0070, 1'b1, 16'h0010, 1'b1, 1'b0, 16'h0600, 1'b0, 1'b1);
        expect_lk("flush_same", 1'b1, 1'b1, 16'h0500);
        look(1'b1, 16'h0070);
        expect_lk("flush_a", 1'b0, 1'b0, 16'h0072);
        look(1'b1, 16'h0010);
        expect_all("flush_b", 1'b0, 1'b0, 16'h0012, 4'd13, 4'd11, 4'd2);

        // lookup_en low masks the hit and freezes the stats
        upd(16'h0010, 1'b1, 1'b0, 16'h0100, 1'b0);
        look(1'b0, 16'h0010);
        expect_all("lk_en_mask", 1'b0, 1'b0, 16'h0012, 4'd14, 4'd11, 4'd2);
        look(1'b1, 16'h0010);
        expect_lk("realloc", 1'b1, 1'b1, 16'h0100);
        look(1'b1, 16'hFFFE);
        expect_all("wrap", 1'b0, 1'b0, 16'h0000, 4'd15, 4'd12, 4'd2);
        for (int i = 0; i < 3; i++) begin
            look(1'b1, 16'h0010);
            expect_lk("hit_run", 1'b1, 1'b1, 16'h0100);
        end
        look(1'b1, 16'h0010);
        expect_all("stat_sat", 1'b1, 1'b1, 16'h0100, 4'd15, 4'd15, 4'd2);

        // Reset mid-run with an update pending: update must be discarded
        drive(1'b1, 16'h0040, 1'b1, 16'h0040, 1'b1, 1'b0, 16'h0700, 1'b1, 1'b0);
        rst = 1'b0;
        expect_all("rst_mid", 1'b0, 1'b0, 16'h0042, 4'd0, 4'd0, 4'd0);
        look(1'b0, 16'h0040);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            look(1'b1, 16'h0040);
            expect_all("lk_count", 1'b0, 1'b0, 16'h0042, (i > 15) ? 4'd15 : 4'(i), 4'd0, 4'd0);
        end
        look(1'b0, 16'h0040);
        expect_all("lk_sat", 1'b0, 1'b0, 16'h0042, 4'd15, 4'd0, 4'd0);

        @(posedge clk);
        #1;
        drv_chk = 1'b0;
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
